apb_master: RTL and testbench

APB requester that turns a simple valid/ready command stream into compliant APB SETUP/ACCESS transfers toward the I2C core's APB completer.
It returns read data, slave error and timeout status on a valid/ready response stream.
It sits between the controller/sequencer logic and the APB bus, and drives one transfer at a time.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_master.sv | 148 ++++++++++++++
 tb/tb_apb_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester: FSM encoding, register map, default timeout.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  localparam logic [31:0] APB_ADDR_TX      = 32'h0;
  localparam logic [31:0] APB_ADDR_RX      = 32'h4;
  localparam logic [31:0] APB_ADDR_CONFIG  = 32'h8;
  localparam logic [31:0] APB_ADDR_TIMEOUT = 32'hC;

  localparam int TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer and one held response.
// Accept-to-response is 3 cycles with zero wait states; a stuck completer is aborted after TIMEOUT_CYC ACCESS cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  apb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked first so a completion in the last counted cycle beats the abort.
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign PSELx       = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, slave error, timeout, backpressure, async reset.
module tb_apb_master;
  import apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSELx, PENABLE, PWRITE, PREADY, PSLVERR, busy;
  logic [31:0] PADDR, PWDATA, PRDATA;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc;
  int n;
  logic [31:0] held;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Present a command and consume the accepting edge; acc marks that edge.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("hs_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    check("rst_psel",    {31'b0, PSELx},     32'd0);
    check("rst_penable", {31'b0, PENABLE},   32'd0);
    check("rst_pwrite",  {31'b0, PWRITE},    32'd0);
    check("rst_paddr",   PADDR,              32'd0);
    check("rst_pwdata",  PWDATA,             32'd0);
    check("rst_rsp_vld", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata",   rsp_rdata,          32'd0);
    check("rst_cmd_rdy", {31'b0, cmd_ready}, 32'd1);
    check("rst_busy",    {31'b0, busy},      32'd0);
    PRESETn = 1'b1;
    tick();

    // Write, PREADY already high: SETUP must not complete early.
    PREADY = 1'b1;
    issue(1'b1, APB_ADDR_CONFIG, 32'h0000_1234);
    check("wr_setup_psel", {31'b0, PSELx},   32'd1);
    check("wr_setup_pen",  {31'b0, PENABLE}, 32'd0);
    check("wr_setup_rdy",  {31'b0, cmd_ready}, 32'd0);
    check("wr_busy",       {31'b0, busy},    32'd1);
    tick();
    check("wr_acc_psel",   {31'b0, PSELx},   32'd1);
    check("wr_acc_pen",    {31'b0, PENABLE}, 32'd1);
    check("wr_acc_paddr",  PADDR,            32'h8);
    check("wr_acc_pwdata", PWDATA,           32'h1234);
    check("wr_acc_pwrite", {31'b0, PWRITE},  32'd1);
    check("wr_acc_novld",  {31'b0, rsp_valid}, 32'd0);
    tick();
    check("wr_rsp_vld",    {31'b0, rsp_valid}, 32'd1);
    check("wr_rsp_cycle",  cyc - acc + 1,    32'd3);
    check("wr_rsp_err",    {31'b0, rsp_err}, 32'd0);
    check("wr_rsp_rdata",  rsp_rdata,        32'd0);
    check("wr_rsp_psel",   {31'b0, PSELx},   32'd0);
    handshake();

    // Read with three wait states.
    PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
    issue(1'b0, APB_ADDR_RX, 32'hFFFF_FFFF);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rd_wait_paddr",  PADDR,            32'h4);
      check("rd_wait_pwrite", {31'b0, PWRITE},  32'd0);
      check("rd_wait_pen",    {31'b0, PENABLE}, 32'd1);
      tick();
    end
    PREADY = 1'b1;
    check("rd_last_psel", {31'b0, PSELx}, 32'd1);
    tick();
    check("rd_rsp_vld",   {31'b0, rsp_valid}, 32'd1);
    check("rd_rsp_cycle", cyc - acc + 1,      32'd6);
    check("rd_rsp_rdata", rsp_rdata,          32'hDEAD_BEEF);
    check("rd_rsp_err",   {31'b0, rsp_err},   32'd0);
    handshake();

    // Slave error on a read.
    PSLVERR = 1'b1; PRDATA = 32'hCAFE_0001;
    issue(1'b0, APB_ADDR_RX, 32'h0);
    tick(); tick();
    check("se_rsp_vld", {31'b0, rsp_valid},   32'd1);
    check("se_err",     {31'b0, rsp_err},     32'd1);
    check("se_timeout", {31'b0, rsp_timeout}, 32'd0);
    check("se_rdata",   rsp_rdata,            32'hCAFE_0001);
    handshake();
    PSLVERR = 1'b0;

    // Timeout: PREADY never rises.
    PREADY = 1'b0;
    issue(1'b1, 32'h10, 32'hA5A5_A5A5);
    tick();
    n = 0;
    while (PENABLE && n < 40) begin
      n++;
      tick();
    end
    check("to_access_cycles", n,                    32'd16);
    check("to_psel",          {31'b0, PSELx},       32'd0);
    check("to_rsp_vld",       {31'b0, rsp_valid},   32'd1);
    check("to_err",           {31'b0, rsp_err},     32'd1);
    check("to_timeout",       {31'b0, rsp_timeout}, 32'd1);
    check("to_rdata",         rsp_rdata,            32'd0);
    handshake();

    // PREADY arrives in the 16th ACCESS cycle: normal completion wins.
    PRDATA = 32'h0000_55AA;
    issue(1'b0, 32'h10, 32'h0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    PREADY = 1'b1;
    check("to16_still_acc", {31'b0, PENABLE}, 32'd1);
    tick();
    check("to16_rsp_vld", {31'b0, rsp_valid},   32'd1);
    check("to16_timeout", {31'b0, rsp_timeout}, 32'd0);
    check("to16_err",     {31'b0, rsp_err},     32'd0);
    check("to16_rdata",   rsp_rdata,            32'h0000_55AA);
    handshake();

    // Backpressure with cmd_valid held high throughout.
    PRDATA = 32'h0BAD_F00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = APB_ADDR_TIMEOUT; cmd_wdata = '0;
    tick(); tick(); tick();
    check("bp_rsp_vld", {31'b0, rsp_valid}, 32'd1);
    held = rsp_rdata;
    check("bp_rdata", held, 32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_vld",   {31'b0, rsp_valid}, 32'd1);
      check("bp_hold_rdata", rsp_rdata,          32'h0BAD_F00D);
      check("bp_hold_rdy",   {31'b0, cmd_ready}, 32'd0);
      check("bp_hold_psel",  {31'b0, PSELx},     32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_hs_vld",  {31'b0, rsp_valid}, 32'd0);
    check("bp_hs_rdy",  {31'b0, cmd_ready}, 32'd1);
    check("bp_hs_psel", {31'b0, PSELx},     32'd0);
    tick();
    cmd_valid = 1'b0;
    check("bp_next_psel", {31'b0, PSELx},   32'd1);
    check("bp_next_pen",  {31'b0, PENABLE}, 32'd0);
    check("bp_next_addr", PADDR,            32'hC);
    tick(); tick();
    check("bp_next_vld", {31'b0, rsp_valid}, 32'd1);
    handshake();

    // Asynchronous reset in the middle of ACCESS.
    PREADY = 1'b0;
    issue(1'b1, APB_ADDR_TX, 32'h1111_2222);
    tick(); tick();
    check("mr_in_access", {31'b0, PENABLE}, 32'd1);
    #1 PRESETn = 1'b0;
    #1;
    check("mr_psel",    {31'b0, PSELx},     32'd0);
    check("mr_penable", {31'b0, PENABLE},   32'd0);
    check("mr_rsp_vld", {31'b0, rsp_valid}, 32'd0);
    check("mr_paddr",   PADDR,              32'd0);
    tick();
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    tick();
    check("mr_rel_rdy",  {31'b0, cmd_ready}, 32'd1);
    check("mr_rel_busy", {31'b0, busy},      32'd0);
    check("mr_rel_vld",  {31'b0, rsp_valid}, 32'd0);
    tick();
    check("mr_rel_psel", {31'b0, PSELx},     32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
